// File: rtl/ex_muldiv_unit_if.sv
// Request/response bundle between the execute stage and the M-extension unit.
// The master side issues operations; the slave side is the iterative unit.
interface ex_muldiv_unit_if #(
  parameter int unsigned XLEN = 32,
  parameter int unsigned RD_W = 5
);
  logic            start;
  logic            flush;
  logic [2:0]      funct3;
  logic [RD_W-1:0] rd_in;
  logic [XLEN-1:0] op_a;
  logic [XLEN-1:0] op_b;
  logic            busy;
  logic            done;
  logic [XLEN-1:0] result;
  logic [RD_W-1:0] rd_out;

  modport master (
    output start, flush, funct3, rd_in, op_a, op_b,
    input  busy, done, result, rd_out
  );

  modport slave (
    input  start, flush, funct3, rd_in, op_a, op_b,
    output busy, done, result, rd_out
  );
endinterface

// File: rtl/ex_muldiv_unit.sv
// Iterative RV32M execution unit: shift-add multiplier and restoring divider sharing one
// accumulator pair, one bit per cycle, with a one-cycle done pulse carrying result and rd.
module ex_muldiv_unit #(
  parameter int unsigned XLEN = 32,
  parameter int unsigned RD_W = 5
) (
  input logic              clk,
  input logic              rst,
  ex_muldiv_unit_if.slave  bus
);
  localparam int unsigned CNT_W = $clog2(XLEN) + 1;

  localparam logic [2:0] F3Mul    = 3'b000;
  localparam logic [2:0] F3Mulh   = 3'b001;
  localparam logic [2:0] F3Mulhsu = 3'b010;
  localparam logic [2:0] F3Mulhu  = 3'b011;
  localparam logic [2:0] F3Div    = 3'b100;
  localparam logic [2:0] F3Divu   = 3'b101;
  localparam logic [2:0] F3Rem    = 3'b110;
  localparam logic [2:0] F3Remu   = 3'b111;

  typedef enum logic [1:0] {StIdle, StCalc, StDone} state_e;

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q;
  logic [2:0]        funct3_q;
  logic [RD_W-1:0]   rd_q;
  logic [XLEN-1:0]   result_q;
  logic              sign_q;
  logic [XLEN-1:0]   opnd_q;
  logic [XLEN-1:0]   hi_q;
  logic [XLEN-1:0]   lo_q;

  // Request decode: operand magnitudes, result sign and the early-out cases.
  logic            a_signed, b_signed, a_neg, b_neg;
  logic [XLEN-1:0] abs_a, abs_b;
  logic            is_div, div_zero, div_ovf, special;
  logic [XLEN-1:0] special_val;
  logic            req_sign;
  logic            accept;

  always_comb begin
    a_signed = (bus.funct3 == F3Mulh) || (bus.funct3 == F3Mulhsu) ||
               (bus.funct3 == F3Div)  || (bus.funct3 == F3Rem);
    b_signed = (bus.funct3 == F3Mulh) || (bus.funct3 == F3Div) || (bus.funct3 == F3Rem);
    a_neg    = a_signed && bus.op_a[XLEN-1];
    b_neg    = b_signed && bus.op_b[XLEN-1];
    abs_a    = a_neg ? -bus.op_a : bus.op_a;
    abs_b    = b_neg ? -bus.op_b : bus.op_b;
    // Remainder follows the dividend; everything else follows the operand sign product.
    req_sign = (bus.funct3 == F3Rem) ? a_neg : (a_neg ^ b_neg);

    is_div   = bus.funct3[2];
    div_zero = is_div && (bus.op_b == '0);
    div_ovf  = ((bus.funct3 == F3Div) || (bus.funct3 == F3Rem)) &&
               (bus.op_a == {1'b1, {(XLEN-1){1'b0}}}) && (bus.op_b == '1);
    special  = div_zero || div_ovf;
    if (div_zero) begin
      special_val = bus.funct3[1] ? bus.op_a : '1;
    end else begin
      special_val = bus.funct3[1] ? '0 : bus.op_a;
    end

    accept = bus.start && !bus.flush && ((state_q == StIdle) || (state_q == StDone));
  end

  // One iteration of either datapath plus the final sign correction.
  logic [XLEN:0]     mul_sum;
  logic [XLEN:0]     div_shift;
  logic              div_ge;
  logic [XLEN-1:0]   div_sub;
  logic [XLEN-1:0]   hi_n, lo_n;
  logic [2*XLEN-1:0] prod, prod_s;
  logic [XLEN-1:0]   quo_s, rem_s, final_res;
  logic              last;

  always_comb begin
    mul_sum   = {1'b0, hi_q} + (lo_q[0] ? {1'b0, opnd_q} : '0);
    div_shift = {hi_q, lo_q[XLEN-1]};
    div_ge    = div_shift >= {1'b0, opnd_q};
    div_sub   = div_shift[XLEN-1:0] - opnd_q;

    if (funct3_q[2]) begin
      hi_n = div_ge ? div_sub : div_shift[XLEN-1:0];
      lo_n = {lo_q[XLEN-2:0], div_ge};
    end else begin
      hi_n = mul_sum[XLEN:1];
      lo_n = {mul_sum[0], lo_q[XLEN-1:1]};
    end

    prod   = {hi_n, lo_n};
    prod_s = sign_q ? -prod : prod;
    quo_s  = sign_q ? -lo_n : lo_n;
    rem_s  = sign_q ? -hi_n : hi_n;

    unique case (funct3_q)
      F3Mul:                     final_res = prod_s[XLEN-1:0];
      F3Mulh, F3Mulhsu, F3Mulhu: final_res = prod_s[2*XLEN-1:XLEN];
      F3Div, F3Divu:             final_res = quo_s;
      F3Rem, F3Remu:             final_res = rem_s;
      default:                   final_res = '0;
    endcase

    last = (cnt_q == CNT_W'(XLEN - 1));
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle, StDone: state_d = accept ? (special ? StDone : StCalc) : StIdle;
      StCalc: begin
        if (bus.flush) begin
          state_d = StIdle;
        end else if (last) begin
          state_d = StDone;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= StIdle;
      cnt_q    <= '0;
      funct3_q <= '0;
      rd_q     <= '0;
      result_q <= '0;
      sign_q   <= 1'b0;
      opnd_q   <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        funct3_q <= bus.funct3;
        rd_q     <= bus.rd_in;
        cnt_q    <= '0;
        sign_q   <= req_sign;
        hi_q     <= '0;
        // Multiplier: opnd is the multiplicand, lo the multiplier.
        // Divider: opnd is the divisor, lo the dividend shifting into the quotient.
        opnd_q   <= is_div ? abs_b : abs_a;
        lo_q     <= is_div ? abs_a : abs_b;
        if (special) begin
          result_q <= special_val;
        end
      end else if ((state_q == StCalc) && !bus.flush) begin
        hi_q  <= hi_n;
        lo_q  <= lo_n;
        cnt_q <= cnt_q + CNT_W'(1);
        if (last) begin
          result_q <= final_res;
        end
      end
    end
  end

  assign bus.busy   = (state_q == StCalc);
  assign bus.done   = (state_q == StDone);
  assign bus.result = result_q;
  assign bus.rd_out = rd_q;
endmodule

// File: tb/tb_ex_muldiv_unit.sv
// Scoreboard bench for ex_muldiv_unit: randomized and directed RV32M requests against an
// arithmetic reference model, plus a short XLEN=16 width sweep.
module tb_ex_muldiv_unit;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  ex_muldiv_unit_if #(.XLEN(32), .RD_W(5)) bus32 ();
  ex_muldiv_unit_if #(.XLEN(16), .RD_W(5)) bus16 ();

  ex_muldiv_unit #(.XLEN(32), .RD_W(5)) u_dut32 (.clk(clk), .rst(rst), .bus(bus32));
  ex_muldiv_unit #(.XLEN(16), .RD_W(5)) u_dut16 (.clk(clk), .rst(rst), .bus(bus16));

  typedef struct {
    logic [31:0] res;
    logic [4:0]  rd;
    int          due;
    int          busy_len;
  } exp_t;

  exp_t sb_q[$];
  int   errors = 0;
  int   checks = 0;
  int   cyc = 0;
  int   busy_run = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // RISC-V M-extension semantics in plain 64-bit arithmetic.
  function automatic logic [31:0] ref32(input logic [2:0] f3, input logic [31:0] a,
                                        input logic [31:0] b);
    logic signed [63:0] sa, sb, ub, sp;
    logic        [63:0] up;
    bit                 ovf;
    sa  = {{32{a[31]}}, a};
    sb  = {{32{b[31]}}, b};
    ub  = {32'd0, b};
    ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    case (f3)
      3'b000: begin sp = sa * sb; return sp[31:0]; end
      3'b001: begin sp = sa * sb; return sp[63:32]; end
      3'b010: begin sp = sa * ub; return sp[63:32]; end
      3'b011: begin up = {32'd0, a} * {32'd0, b}; return up[63:32]; end
      3'b100: begin
        if (b == 0) return 32'hFFFF_FFFF;
        if (ovf) return a;
        sp = sa / sb; return sp[31:0];
      end
      3'b101: return (b == 0) ? 32'hFFFF_FFFF : a / b;
      3'b110: begin
        if (b == 0) return a;
        if (ovf) return 32'd0;
        sp = sa % sb; return sp[31:0];
      end
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  function automatic bit is_special(input logic [2:0] f3, input logic [31:0] a,
                                    input logic [31:0] b);
    return f3[2] && ((b == 0) || (!f3[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF));
  endfunction

  function automatic logic [31:0] pick_operand();
    case ($urandom % 6)
      0:       return 32'd0;
      1:       return 32'hFFFF_FFFF;
      2:       return 32'h8000_0000;
      3:       return $urandom % 16;
      default: return $urandom;
    endcase
  endfunction

  // Monitor: every done pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin : monitor
    exp_t e;
    if (bus32.done) begin
      if (sb_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done: got result %0h with no request outstanding (cycle %0d)",
                 bus32.result, cyc);
      end else begin
        e = sb_q.pop_front();
        check("result", bus32.result, e.res);
        check("rd_out", bus32.rd_out, e.rd);
        check("done_cycle", cyc, e.due);
        check("busy_len", busy_run, e.busy_len);
      end
      busy_run = 0;
    end else if (bus32.busy) begin
      busy_run++;
    end else begin
      busy_run = 0;
    end
  end

  // Called at posedge+1; returns at posedge+1 after the start edge.
  task automatic issue(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] rd, input bit track);
    exp_t e;
    bus32.start  = 1'b1;
    bus32.funct3 = f3;
    bus32.op_a   = a;
    bus32.op_b   = b;
    bus32.rd_in  = rd;
    if (track) begin
      e.res      = ref32(f3, a, b);
      e.rd       = rd;
      e.due      = cyc + (is_special(f3, a, b) ? 1 : 33);
      e.busy_len = is_special(f3, a, b) ? 0 : 32;
      sb_q.push_back(e);
    end
    @(posedge clk); #1;
    bus32.start = 1'b0;
  endtask

  task automatic wait_done();
    int n = 0;
    while (!bus32.done && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    if (!bus32.done) begin
      checks++;
      errors++;
      $display("FAIL done_timeout: got no done within %0d cycles, required done=1", n);
    end
  endtask

  task automatic run_op(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] rd, input bit junk, input bit b2b);
    issue(f3, a, b, rd, 1'b1);
    if (junk && bus32.busy) begin
      repeat ($urandom % 20) begin
        @(posedge clk); #1;
      end
      bus32.start  = 1'b1;
      bus32.funct3 = 3'($urandom);
      bus32.op_a   = $urandom;
      bus32.op_b   = $urandom;
      bus32.rd_in  = 5'($urandom);
      @(posedge clk); #1;
      bus32.start = 1'b0;
    end
    wait_done();
    if (!b2b) begin
      repeat (1 + $urandom % 3) begin
        @(posedge clk); #1;
      end
    end
  endtask

  task automatic run16(input string name, input logic [2:0] f3, input logic [15:0] a,
                       input logic [15:0] b, input logic [15:0] exp_res, input int exp_lat);
    int c0;
    int n = 0;
    c0 = cyc;
    bus16.start  = 1'b1;
    bus16.funct3 = f3;
    bus16.op_a   = a;
    bus16.op_b   = b;
    bus16.rd_in  = 5'd9;
    @(posedge clk); #1;
    bus16.start = 1'b0;
    while (!bus16.done && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    check({name, "_done"}, bus16.done, 1'b1);
    check({name, "_result"}, bus16.result, exp_res);
    check({name, "_latency"}, cyc - c0, exp_lat);
    @(posedge clk); #1;
  endtask

  initial begin
    rst = 1'b1;
    {bus32.start, bus32.flush, bus32.funct3, bus32.rd_in, bus32.op_a, bus32.op_b} = '0;
    {bus16.start, bus16.flush, bus16.funct3, bus16.rd_in, bus16.op_a, bus16.op_b} = '0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    check("reset_busy", bus32.busy, 1'b0);
    check("reset_done", bus32.done, 1'b0);
    check("reset_result", bus32.result, 32'd0);
    check("reset_rd_out", bus32.rd_out, 5'd0);

    // Reset in the middle of an untracked MUL: no done may follow.
    issue(3'b000, 32'd7, 32'd6, 5'd5, 1'b0);
    repeat (8) begin
      @(posedge clk); #1;
    end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("midrst_busy", bus32.busy, 1'b0);
    check("midrst_done", bus32.done, 1'b0);
    check("midrst_result", bus32.result, 32'd0);
    repeat (40) begin
      @(posedge clk); #1;
    end

    run_op(3'b000, 32'h0000_0007, 32'h0000_0006, 5'd5, 1'b0, 1'b0);
    run_op(3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd6, 1'b0, 1'b0);
    run_op(3'b001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd7, 1'b0, 1'b0);
    run_op(3'b100, 32'hFFFF_FFF9, 32'h0000_0002, 5'd8, 1'b0, 1'b0);
    run_op(3'b110, 32'hFFFF_FFF9, 32'h0000_0002, 5'd9, 1'b0, 1'b0);
    run_op(3'b010, 32'hFFFF_FFFF, 32'h0000_0002, 5'd10, 1'b0, 1'b0);
    run_op(3'b101, 32'h0000_1234, 32'h0000_0000, 5'd11, 1'b0, 1'b0);
    run_op(3'b110, 32'h0000_1234, 32'h0000_0000, 5'd12, 1'b0, 1'b0);
    run_op(3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 5'd13, 1'b0, 1'b0);
    run_op(3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 5'd14, 1'b0, 1'b0);
    run_op(3'b101, 32'd1000, 32'd3, 5'd15, 1'b1, 1'b0);

    // Flush mid-CALC drops the op.
    issue(3'b101, 32'd100, 32'd7, 5'd16, 1'b0);
    repeat (4) begin
      @(posedge clk); #1;
    end
    bus32.flush = 1'b1;
    @(posedge clk); #1;
    bus32.flush = 1'b0;
    check("flush_busy", bus32.busy, 1'b0);
    check("flush_done", bus32.done, 1'b0);
    repeat (40) begin
      @(posedge clk); #1;
    end

    // Flush together with start in IDLE: request dropped.
    bus32.flush = 1'b1;
    bus32.start = 1'b1;
    bus32.funct3 = 3'b101;
    bus32.op_a = 32'd55;
    bus32.op_b = 32'd0;
    @(posedge clk); #1;
    bus32.flush = 1'b0;
    bus32.start = 1'b0;
    check("flushstart_busy", bus32.busy, 1'b0);
    check("flushstart_done", bus32.done, 1'b0);
    repeat (5) begin
      @(posedge clk); #1;
    end

    // Flush during DONE still presents the result.
    issue(3'b000, 32'd12, 32'd12, 5'd17, 1'b1);
    wait_done();
    bus32.flush = 1'b1;
    @(posedge clk); #1;
    bus32.flush = 1'b0;
    check("flushdone_after", bus32.done, 1'b0);

    // Randomized traffic with back-to-back issue and ignored starts during CALC.
    for (int i = 0; i < 250; i++) begin
      run_op(3'($urandom), pick_operand(), pick_operand(), 5'($urandom),
             ($urandom % 4) == 0, ($urandom % 2) == 1);
    end
    repeat (3) begin
      @(posedge clk); #1;
    end

    run16("w16_divu", 3'b101, 16'hFFFF, 16'h0010, 16'h0FFF, 17);
    run16("w16_mul", 3'b000, 16'h0007, 16'h0006, 16'h002A, 17);
    run16("w16_div", 3'b100, 16'hFFF9, 16'h0002, 16'hFFFD, 17);
    run16("w16_mulhu", 3'b011, 16'hFFFF, 16'hFFFF, 16'hFFFE, 17);
    run16("w16_divz", 3'b101, 16'h1234, 16'h0000, 16'hFFFF, 1);

    for (int n = 0; n < 100 && sb_q.size() != 0; n++) begin
      @(posedge clk); #1;
    end
    if (sb_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain: got %0d outstanding results, required 0", sb_q.size());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/ex_muldiv_unit.md
Name: ex_muldiv_unit

Overview:
- Parametrised multi-cycle M-extension execution unit, sitting beside the single-cycle ALU in the execute stage.
- Handles all eight RV32M operations (MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU), selected by funct3.
- Uses an iterative shift-add multiplier and a restoring divider, one bit per cycle.
- Asserts busy to stall IF/ID/EX while iterating, then returns result plus destination register to the execute-stage result mux with a one-cycle done pulse.

Parameters:
- XLEN, 32, operand and result width; must be even and ≥ 8.
- RD_W, 5, destination register index width.
- CNT_W, $clog2(XLEN)+1, iteration counter width (derived, not overridden).

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  synchronous, active-high reset
- start  in  1  operation request from execute stage, qualified by control word
- flush  in  1  abort in-flight operation (branch/jump redirect)
- funct3  in  3  RV32M operation select
- rd_in  in  RD_W  destination register of the request
- op_a  in  XLEN  rs1 value (regfilea)
- op_b  in  XLEN  rs2 value (regfileb)
- busy  out  1  high while iterating; pipeline must hold EX inputs stable
- done  out  1  one-cycle pulse; result and rd_out valid
- result  out  XLEN  final value
- rd_out  out  RD_W  destination register for writeback

Behaviour:
- Clock and reset: one clock; reset is synchronous and active-high (rst sampled on clk rising edge).
- Reset values:
  - state = IDLE
  - busy = 0, done = 0, result = 0, rd_out = 0
  - counter and internal accumulators = 0
- States:
  - IDLE: waiting for start.
  - CALC: busy = 1, one iteration per cycle.
  - DONE: done = 1, busy = 0, result held.
- Transitions:
  - IDLE, start=1 → CALC. Counter = 0. Latch funct3 and rd_in. Latch |op_a| and |op_b| according to signedness: MULH both signed, MULHSU a signed, DIV/REM signed, others unsigned. Latch the result sign.
  - IDLE, start=1 with a special case → DONE directly (latency 1). Special cases:
    - Division by zero (op_b = 0): DIV/DIVU result all ones; REM/REMU result op_a.
    - Signed overflow (DIV/REM with op_a = 2^(XLEN-1) and op_b = all ones): DIV result op_a; REM result 0.
  - CALC: counter increments each cycle. When counter = XLEN-1 the next edge → DONE. The final sign correction (two's complement negate if the sign flag is set) is registered into result on that edge.
  - DONE → IDLE next edge, or → CALC/DONE if start = 1 in the DONE cycle (back-to-back issue permitted).
- Latency:
  - Normal ops: done is high in the cycle after XLEN+1 rising edges from the start edge (33 edges for XLEN=32).
  - busy is high for exactly XLEN cycles.
- Result selection:
  - MUL: low XLEN bits of the 2·XLEN product.
  - MULH*: high XLEN bits.
  - DIV*: quotient. REM*: remainder.
- Sign rules:
  - Remainder takes the sign of the dividend.
  - Quotient is negated when the operand signs differ.
  - MULHSU sign = sign of op_a.
- start while state = CALC is ignored (no restart, no error).
- flush:
  - In CALC: → IDLE next edge, busy = 0, no done.
  - In DONE: done is still presented this cycle; the consumer gates writeback.
  - flush with start in the same cycle in IDLE: flush wins, request dropped.
- rst has priority over flush and start in every state, including mid-CALC.
- result and rd_out hold their last values in IDLE. Only done indicates validity.

Test Plan:
- Reset mid-operation: start MUL 7×6, assert rst at cycle 10 → next cycle busy=0, done=0, result=0; no done pulse follows.
- MUL/MULHU (XLEN=32): MUL 0x0000_0007 × 0x0000_0006 with rd=5 → busy for 32 cycles, then done=1, result=0x0000_002A, rd_out=5. MULHU 0xFFFF_FFFF × 0xFFFF_FFFF → 0xFFFF_FFFE.
- Signed multiply/divide: MULH 0xFFFF_FFFF × 0xFFFF_FFFF → 0x0000_0000. DIV −7/2 → 0xFFFF_FFFD. REM −7/2 → 0xFFFF_FFFF. MULHSU 0xFFFF_FFFF × 0x0000_0002 → 0xFFFF_FFFF.
- Special cases: DIVU 0x1234/0 → done after 1 edge, result=0xFFFF_FFFF. REM 0x1234 % 0 → 0x0000_1234. DIV 0x8000_0000 / 0xFFFF_FFFF → 0x8000_0000. REM of the same operands → 0.
- Flush and ignored start: start DIVU 100/7, assert flush at cycle 5 → busy drops next cycle, no done. A start pulsed during CALC of a separate op is ignored, and that op still returns its own result.
- Back-to-back and width sweep: start in the DONE cycle → second result follows with the same latency. Re-run MUL/DIV at XLEN=16: DIVU 0xFFFF/0x0010 → 0x0FFF after 17 edges.
